// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type, counter widths and clog2 helper for the stream arbiter
package arb_pkg;
  typedef enum logic [1:0] {IDLE, ACK, SEND} state_t;
  localparam int ARB_CNT_W = 8;
  localparam int ARB_WDOG_W = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder, first request after last with wrap
module rr_pick import arb_pkg::*; #(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // walk offsets from farthest to nearest so the nearest request after last wins
  always_comb begin
    valid = |req;
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last) + k) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin merge of N stb/ack streams onto one registered output stream
// ARB_WATCHDOG_EN builds a sticky stall watchdog on out_ack driving exception
module stream_rr_arbiter import arb_pkg::*; #(
  parameter int N_INPUTS = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 1,
  parameter int TIMEOUT = 1024,
  localparam int IW = clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      exception,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]       in_stb,
  output logic [N_INPUTS-1:0]       in_ack,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_stb,
  input  logic                      out_ack,
  output logic [IW-1:0]             grant
);
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick_idx;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] src [N_INPUTS];
  logic pick_valid;
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_src
    assign src[i] = in_data[i*WIDTH +: WIDTH];
  end
  rr_pick #(.N(N_INPUTS)) u_pick (
    .req(in_stb),
    .last(last_q),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  assign cnt_inc = cnt_q + ARB_CNT_W'(1);
  assign out_data = data_q;
  assign grant = grant_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    cnt_d = cnt_q;
    data_d = data_q;
    in_ack = '0;
    out_stb = state_q == SEND;
    if (state_q == ACK) in_ack[grant_q] = 1'b1;
    case (state_q)
      IDLE: if (pick_valid) begin
        grant_d = pick_idx;
        cnt_d = '0;
        state_d = ACK;
      end
      ACK: begin
        state_d = in_stb[grant_q] ? SEND : IDLE;
        data_d = in_stb[grant_q] ? src[grant_q] : data_q;
      end
      SEND: if (out_ack) begin
        cnt_d = cnt_inc;
        state_d = (cnt_inc < ARB_CNT_W'(BURST) && in_stb[grant_q]) ? ACK : IDLE;
        last_d = (state_d == IDLE) ? grant_q : last_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= IW'(N_INPUTS - 1);
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
    end
  end
`ifdef ARB_WATCHDOG_EN
  logic [ARB_WDOG_W-1:0] wdog_q, wdog_d;
  logic exc_q, exc_d;
  // saturate at TIMEOUT so a long stall never wraps the counter
  always_comb begin
    wdog_d = (state_q == SEND && !out_ack) ?
             ((wdog_q == ARB_WDOG_W'(TIMEOUT)) ? wdog_q : wdog_q + ARB_WDOG_W'(1)) : '0;
    exc_d = exc_q | (wdog_d == ARB_WDOG_W'(TIMEOUT));
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_q <= '0;
      exc_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      exc_q <= exc_d;
    end
  end
  assign exception = exc_q;
`else
  assign exception = 1'b0;
`endif
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: scoreboard bench for two arbiter instances (BURST=1 and BURST=3)
module tb_stream_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
`ifdef ARB_WATCHDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N*W-1:0] ind [2];
  logic [N-1:0] stb [2];
  logic [N-1:0] ack [2];
  logic [W-1:0] odata [2];
  logic ostb [2];
  logic oack [2];
  logic exc [2];
  logic [1:0] gnt [2];
  int vecs = 0;
  int errs = 0;
  int rem [2][N];
  int sent [2][N];
  logic [W-1:0] base [2][N];
  bit pend [2][N];
  logic [33:0] exp_q0 [$];
  logic [33:0] exp_q1 [$];
  logic [33:0] e0, e1;
  int src_cnt [N];
  int cyc = 0;
  int last_t = 0;
  int nb = 0;
  int bad;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_rr_arbiter #(.N_INPUTS(N), .WIDTH(W), .BURST(1), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .exception(exc[0]), .in_data(ind[0]), .in_stb(stb[0]),
    .in_ack(ack[0]), .out_data(odata[0]), .out_stb(ostb[0]), .out_ack(oack[0]), .grant(gnt[0])
  );
  stream_rr_arbiter #(.N_INPUTS(N), .WIDTH(W), .BURST(3), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .exception(exc[1]), .in_data(ind[1]), .in_stb(stb[1]),
    .in_ack(ack[1]), .out_data(odata[1]), .out_stb(ostb[1]), .out_ack(oack[1]), .grant(gnt[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic load(input int d, input int i, input int n, input logic [W-1:0] b);
    rem[d][i] = n;
    sent[d][i] = 0;
    base[d][i] = b;
  endtask

  task automatic wait_stb(input int d, input string nm);
    int n = 0;
    while (ostb[d] !== 1'b1 && n < 30) begin
      at_neg();
      n++;
    end
    chk(nm, ostb[d], 1'b1);
  endtask

  task automatic wait_empty(input int d, input int lim, input string nm);
    int n = 0;
    while ((d == 0 ? exp_q0.size() : exp_q1.size()) != 0 && n < lim) begin
      at_neg();
      n++;
    end
    chk(nm, d == 0 ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  // producers: hold stb/data until acked, then advance to the next word
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        if (pend[d][i]) begin
          sent[d][i]++;
          rem[d][i]--;
        end
        stb[d][i] = rem[d][i] > 0;
        ind[d][i*W +: W] = base[d][i] + W'(sent[d][i]);
        pend[d][i] = stb[d][i] && ack[d][i];
      end
  end

  always @(negedge clk)
    if (ostb[0] === 1'b1 && oack[0] === 1'b1) begin
      if (exp_q0.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL a_unexpected: got %0h from %0d, expected no word", odata[0], gnt[0]);
      end else begin
        e0 = exp_q0.pop_front();
        chk("a_word", {gnt[0], odata[0]}, e0);
        src_cnt[gnt[0]]++;
      end
    end

  always @(negedge clk)
    if (ostb[1] === 1'b1 && oack[1] === 1'b1) begin
      if (exp_q1.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL b_unexpected: got %0h from %0d, expected no word", odata[1], gnt[1]);
      end else begin
        e1 = exp_q1.pop_front();
        chk("b_word", {gnt[1], odata[1]}, e1);
        if (nb > 0) chk("b_spacing", cyc - last_t, (nb % 3 == 0) ? 3 : 2);
        last_t = cyc;
        nb++;
      end
    end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        rem[d][i] = 0;
        sent[d][i] = 0;
        base[d][i] = '0;
        pend[d][i] = 1'b0;
      end
      stb[d] = '0;
      ind[d] = '0;
      oack[d] = 1'b0;
    end
    for (int i = 0; i < N; i++) src_cnt[i] = 0;
    repeat (3) tick();
    at_neg();
    chk("rst_in_ack", ack[0], 0);
    chk("rst_out_stb", ostb[0], 0);
    chk("rst_out_data", odata[0], 0);
    chk("rst_grant", gnt[0], 0);
    chk("rst_exception", exc[0], 0);
    chk("rst_b_out_stb", ostb[1], 0);
    tick();
    rst = 1'b1;
    tick();
    // single source 2, sink always ready
    oack[0] = 1'b1;
    exp_q0.push_back({2'd2, 32'hDEADBEEF});
    load(0, 2, 1, 32'hDEADBEEF);
    at_neg();
    chk("ss_c0_in_ack", ack[0], 0);
    at_neg();
    chk("ss_c1_in_ack", ack[0], 4'b0100);
    chk("ss_c1_out_stb", ostb[0], 0);
    at_neg();
    chk("ss_c2_out_stb", ostb[0], 1);
    chk("ss_c2_out_data", odata[0], 32'hDEADBEEF);
    chk("ss_c2_grant", gnt[0], 2);
    chk("ss_c2_in_ack", ack[0], 0);
    wait_empty(0, 20, "ss_drain");
    // back-pressure on source 1, then reset drops the held word
    tick();
    oack[0] = 1'b0;
    load(0, 1, 1, 32'hCAFE0001);
    wait_stb(0, "bp_send_reached");
    chk("bp_out_data", odata[0], 32'hCAFE0001);
    chk("bp_grant", gnt[0], 1);
    bad = 0;
    repeat (50) begin
      at_neg();
      if (odata[0] !== 32'hCAFE0001 || ack[0] !== 4'b0000 || ostb[0] !== 1'b1) bad++;
    end
    chk("bp_unstable_cycles", bad, 0);
    tick();
    reset_pulse();
    chk("bp_rst_out_stb", ostb[0], 0);
    chk("bp_rst_in_ack", ack[0], 0);
    chk("bp_rst_out_data", odata[0], 0);
    chk("bp_rst_grant", gnt[0], 0);
    oack[0] = 1'b1;
    exp_q0.push_back({2'd0, 32'hA0});
    exp_q0.push_back({2'd3, 32'hA3});
    load(0, 0, 1, 32'hA0);
    load(0, 3, 1, 32'hA3);
    wait_empty(0, 40, "post_rst_drain");
    // fairness: four sources, 25 words each
    tick();
    reset_pulse();
    for (int i = 0; i < N; i++) src_cnt[i] = 0;
    for (int k = 0; k < 25; k++)
      for (int i = 0; i < N; i++) exp_q0.push_back({2'(i), 32'h1000_0000 * (i + 1) + 32'(k)});
    for (int i = 0; i < N; i++) load(0, i, 25, 32'h1000_0000 * (i + 1));
    wait_empty(0, 1000, "fair_drain");
    for (int i = 0; i < N; i++) chk($sformatf("fair_count_%0d", i), src_cnt[i], 25);
    // watchdog: stall in SEND
    tick();
    reset_pulse();
    oack[0] = 1'b0;
    load(0, 0, 1, 32'h5EED);
    wait_stb(0, "wd_send_reached");
    repeat (15) at_neg();
    chk("wd_exc_at_15", exc[0], 0);
    at_neg();
    chk("wd_exc_at_16", exc[0], WD);
    exp_q0.push_back({2'd0, 32'h5EED});
    tick();
    oack[0] = 1'b1;
    repeat (5) at_neg();
    chk("wd_exc_sticky", exc[0], WD);
    wait_empty(0, 20, "wd_drain");
    tick();
    reset_pulse();
    at_neg();
    chk("wd_exc_cleared", exc[0], 0);
    // burst of 3 on the second instance
    tick();
    reset_pulse();
    oack[1] = 1'b1;
    for (int b = 0; b < 3; b++)
      for (int s = 0; s < 2; s++)
        for (int k = 0; k < 3; k++) exp_q1.push_back({2'(s), 32'hB000_0000 + 32'h100 * s + 32'(3 * b + k)});
    load(1, 0, 9, 32'hB000_0000);
    load(1, 1, 9, 32'hB000_0100);
    wait_empty(1, 500, "burst_drain");
    chk("burst_words", nb, 18);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that merges N 32-bit stb/ack producer streams onto one shared output stream, such as `output_rs232_tx` or `output_audio`. Several `main_N` cores can then share one physical sink instead of each owning a port. It registers one word at a time and rotates priority after a configurable burst. An optional stall watchdog raises `exception`, which is ORed into the top-level exception like any core's.

## Interface
- `N_INPUTS`, 4, number of producer streams (2..16)
- `WIDTH`, 32, data width
- `BURST`, 1, max words per grant before priority rotates (1..255)
- `TIMEOUT`, 1024, watchdog stall limit in cycles (only with watchdog enabled)

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  synchronous, active-low reset
- `exception`  out  1  sticky stall flag
- `in_data`  in  N_INPUTS*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
- `in_stb`  in  N_INPUTS  source i has a word
- `in_ack`  out  N_INPUTS  word of source i accepted
- `out_data`  out  WIDTH  registered word to sink
- `out_stb`  out  1  out_data valid
- `out_ack`  in  1  sink accepted word
- `grant`  out  clog2(N_INPUTS)  index of current/last granted source

## Operation
- Handshake, both sides: a word transfers in a cycle where stb and ack are both high. A producer holds stb and data stable until it is acked; the arbiter holds out_stb and out_data until acked.
- FSM states: IDLE, ACK, SEND.
  - IDLE: if any `in_stb`, choose the first set bit searching from `(last+1) mod N_INPUTS` upward with wrap. Register `grant`, clear the burst counter, go to ACK. No request: stay in IDLE.
  - ACK: `in_ack[grant]`=1 (one-hot; all others 0). Capture `in_data[grant]` into the output register, go to SEND. If `in_stb[grant]` is low (protocol violation), drop the capture and return to IDLE; `last` is unchanged.
  - SEND: `out_stb`=1. On `out_ack`, increment the burst counter.
    - If counter < BURST and `in_stb[grant]`=1, go to ACK with the same grant.
    - Otherwise set `last`=grant and go to IDLE.
- `in_ack` and `out_stb` are decoded from registered state only, so there are no combinational stb→ack paths.
- Burst counter is 8 bits; it never wraps because it is bounded by BURST.
- Reset mid-transfer: any word held in SEND is discarded. State returns to IDLE, `last`=N_INPUTS-1 so that source 0 has first priority.

## Timing
- Reset values: `in_ack`=0, `out_stb`=0, `out_data`=0, `grant`=0, `exception`=0, state=IDLE.
- Latency:
  - `in_stb[i]` rising in IDLE at cycle 0 gives `in_ack[i]`=1 in cycle 1 and `out_stb`=1 in cycle 2.
  - With `out_ack` held high, a burst continuation costs 2 cycles per word.
  - A new grant costs 3 cycles per word.
- `out_ack` asserted in the same cycle `out_stb` first rises completes the transfer that cycle.
- Simultaneous requests resolve by round-robin order only; there are no fixed priorities.

## Configuration
- `ARB_WATCHDOG_EN` defined:
  - A 16-bit counter increments each cycle in SEND while `out_ack`=0, and clears on `out_ack` or when leaving SEND.
  - When it reaches TIMEOUT, `exception` goes to 1 and stays at 1 until reset. Arbitration continues normally.
- `ARB_WATCHDOG_EN` undefined: the counter is not built and `exception` is tied to 0.

## Structure
- Shared package `arb_pkg`:
  - state enum (IDLE/ACK/SEND)
  - `clog2` function
  - constant `ARB_CNT_W`=8
  - constant `ARB_WDOG_W`=16
- Sub-module `rr_pick`: combinational rotating priority encoder with inputs req[N], last and outputs valid, idx. It is instantiated once.

## Test plan
- Single source: N=4, source 2 presents 0xDEADBEEF with `out_ack` tied high. Expect `in_ack[2]` in cycle 1, `out_stb` with 0xDEADBEEF in cycle 2, `grant`=2.
- Fairness: all four sources request continuously, BURST=1. Grant order must be 0,1,2,3,0,…, and each source receives exactly 25 of 100 words.
- Burst: BURST=3, sources 0 and 1 request continuously. Words arrive as 3 from 0, then 3 from 1, repeating. Within a burst, `out_stb` edges are spaced 2 cycles apart.
- Back-pressure and reset: hold `out_ack`=0 for 50 cycles while in SEND. `out_data` must stay stable and `in_ack` stay 0. Then pulse `rst` low for one cycle: `out_stb`=0 next cycle and the word is dropped. Afterwards, source 0 is served first.
- Watchdog (`ARB_WATCHDOG_EN`, TIMEOUT=16): stall `out_ack` in SEND. `exception` must rise exactly 16 cycles after SEND entry, stay high after `out_ack` resumes, and clear only on reset. With the macro off, `exception` stays 0.
